// File: rtl/fsic_gpio_pad_ctrl.sv
// Core-side controller for one sky130 gpiov2 pad: serial-loaded configuration,
// pad drive decode, and a synchronized, debounced pad input with edge pulses.
module fsic_gpio_pad_ctrl #(
    parameter int unsigned      CFG_W       = 5,
    parameter logic [CFG_W-1:0] DEFAULT_CFG = '0,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter int unsigned      DEB_W       = 4
) (
    input  logic             axis_clk,
    input  logic             axis_rst_n,
    input  logic             ser_valid,
    input  logic             ser_data,
    input  logic             ser_load,
    output logic             ser_data_out,
    input  logic             core_out,
    output logic             core_in,
    output logic             core_rise,
    output logic             core_fall,
    output logic [CFG_W-1:0] cfg_active,
    input  logic             pad_in,
    output logic             pad_out,
    output logic             pad_oe_n,
    output logic [2:0]       pad_dm,
    output logic             pad_inp_dis,
    output logic             pad_slow,
    output logic             pad_vtrip_sel
);

    localparam logic [1:0]       MODE_OUT = 2'b11;
    localparam logic [DEB_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE0 = 2'd0,
        CHK1  = 2'd1,
        IDLE1 = 2'd2,
        CHK0  = 2'd3
    } deb_state_e;

    logic [CFG_W-1:0]       shreg;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_in;
    logic [1:0]             mode;
    logic                   out_mode;

    deb_state_e       state_q, state_d;
    logic [DEB_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             core_in_d, rise_d, fall_d;

    assign mode         = cfg_active[1:0];
    assign out_mode     = (mode == MODE_OUT);
    assign ser_data_out = shreg[CFG_W-1];

    // Shift chain and active configuration; a load samples the pre-shift value
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            shreg      <= '0;
            cfg_active <= DEFAULT_CFG;
        end else begin
            if (ser_valid) shreg      <= {shreg[CFG_W-2:0], ser_data};
            if (ser_load)  cfg_active <= shreg;
        end
    end

    // Pad drive decode
    always_comb begin
        pad_dm = 3'b001;
        case (mode)
            2'b00: pad_dm = 3'b001;
            2'b01: pad_dm = 3'b010;
            2'b10: pad_dm = 3'b011;
            2'b11: pad_dm = 3'b110;
            default: pad_dm = 3'b001;
        endcase
    end

    assign pad_oe_n      = ~out_mode;
    assign pad_inp_dis   = cfg_active[2];
    assign pad_slow      = cfg_active[3];
    assign pad_vtrip_sel = cfg_active[4];

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) pad_out <= 1'b0;
        else             pad_out <= core_out & out_mode;
    end

    // Input synchronizer; a disabled input reads as constant 0
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) sync_q <= '0;
        else             sync_q <= {sync_q[SYNC_STAGES-2:0], pad_in};
    end

    assign s_in = sync_q[SYNC_STAGES-1] & ~cfg_active[2];

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q   <= IDLE0;
            cnt_q     <= '0;
            core_in   <= 1'b0;
            core_rise <= 1'b0;
            core_fall <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            core_in   <= core_in_d;
            core_rise <= rise_d;
            core_fall <= fall_d;
        end
    end

    // Debounce: a new level is accepted once the saturating count reaches all-ones
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        core_in_d = core_in;
        rise_d    = 1'b0;
        fall_d    = 1'b0;
        cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + DEB_W'(1);
        case (state_q)
            IDLE0: begin
                if (s_in) begin
                    state_d = CHK1;
                    cnt_d   = '0;
                end
            end
            CHK1: begin
                if (!s_in) begin
                    state_d = IDLE0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_MAX) begin
                        state_d   = IDLE1;
                        core_in_d = 1'b1;
                        rise_d    = 1'b1;
                    end
                end
            end
            IDLE1: begin
                if (!s_in) begin
                    state_d = CHK0;
                    cnt_d   = '0;
                end
            end
            CHK0: begin
                if (s_in) begin
                    state_d = IDLE1;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_MAX) begin
                        state_d   = IDLE0;
                        core_in_d = 1'b0;
                        fall_d    = 1'b1;
                    end
                end
            end
            default: state_d = IDLE0;
        endcase
    end

endmodule

// File: tb/tb_fsic_gpio_pad_ctrl.sv
// Directed bench for fsic_gpio_pad_ctrl: two chained instances, upstream is the main target.
module tb_fsic_gpio_pad_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ser_valid, ser_data, ser_load;
    logic       core_out, pad_in;
    logic       up_sdo, up_in, up_rise, up_fall, up_pout, up_oe_n, up_idis, up_slow, up_vtrip;
    logic [4:0] up_cfg;
    logic [2:0] up_dm;
    logic       dn_sdo, dn_in, dn_rise, dn_fall, dn_pout, dn_oe_n, dn_idis, dn_slow, dn_vtrip;
    logic [4:0] dn_cfg;
    logic [2:0] dn_dm;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    fsic_gpio_pad_ctrl u_up (
        .axis_clk(clk), .axis_rst_n(rst_n),
        .ser_valid(ser_valid), .ser_data(ser_data), .ser_load(ser_load), .ser_data_out(up_sdo),
        .core_out(core_out), .core_in(up_in), .core_rise(up_rise), .core_fall(up_fall),
        .cfg_active(up_cfg), .pad_in(pad_in), .pad_out(up_pout), .pad_oe_n(up_oe_n),
        .pad_dm(up_dm), .pad_inp_dis(up_idis), .pad_slow(up_slow), .pad_vtrip_sel(up_vtrip)
    );

    fsic_gpio_pad_ctrl u_dn (
        .axis_clk(clk), .axis_rst_n(rst_n),
        .ser_valid(ser_valid), .ser_data(up_sdo), .ser_load(ser_load), .ser_data_out(dn_sdo),
        .core_out(1'b0), .core_in(dn_in), .core_rise(dn_rise), .core_fall(dn_fall),
        .cfg_active(dn_cfg), .pad_in(1'b0), .pad_out(dn_pout), .pad_oe_n(dn_oe_n),
        .pad_dm(dn_dm), .pad_inp_dis(dn_idis), .pad_slow(dn_slow), .pad_vtrip_sel(dn_vtrip)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Shift the low n bits of bits, MSB first
    task automatic shift_bits(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            ser_valid = 1'b1;
            ser_data  = bits[i];
            tick();
        end
        ser_valid = 1'b0;
        ser_data  = 1'b0;
    endtask

    task automatic load_pulse();
        ser_load = 1'b1;
        tick();
        ser_load = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ser_valid = 1'b0; ser_data = 1'b0; ser_load = 1'b0;
        core_out = 1'b0; pad_in = 1'b0;
        tick(); tick();
        total++; if (up_cfg !== 5'b00000) $display("FAIL reset_cfg: got %b want 00000", up_cfg); else passed++;
        total++; if (up_dm !== 3'b001) $display("FAIL reset_dm: got %b want 001", up_dm); else passed++;
        total++; if (up_oe_n !== 1'b1) $display("FAIL reset_oe_n: got %b want 1", up_oe_n); else passed++;
        total++; if (up_pout !== 1'b0) $display("FAIL reset_pad_out: got %b want 0", up_pout); else passed++;
        total++; if (up_in !== 1'b0) $display("FAIL reset_core_in: got %b want 0", up_in); else passed++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_shift_load();
        shift_bits(16'b10011, 5);
        load_pulse();
        total++; if (up_cfg !== 5'b10011) $display("FAIL load_cfg: got %b want 10011", up_cfg); else passed++;
        total++; if (up_dm !== 3'b110) $display("FAIL load_dm: got %b want 110", up_dm); else passed++;
        total++; if (up_oe_n !== 1'b0) $display("FAIL load_oe_n: got %b want 0", up_oe_n); else passed++;
        total++; if (up_vtrip !== 1'b1) $display("FAIL load_vtrip: got %b want 1", up_vtrip); else passed++;
        total++; if (up_pout !== 1'b0) $display("FAIL pad_out_pre: got %b want 0", up_pout); else passed++;
        core_out = 1'b1;
        tick();
        total++; if (up_pout !== 1'b1) $display("FAIL pad_out_drive: got %b want 1", up_pout); else passed++;
    endtask

    task automatic test_debounce();
        int first;
        int pulses;
        // 10-cycle glitch must be filtered out
        pulses = 0;
        pad_in = 1'b1;
        for (int i = 0; i < 10; i++) begin tick(); if (up_rise) pulses++; end
        pad_in = 1'b0;
        for (int i = 0; i < 30; i++) begin tick(); if (up_rise || up_fall) pulses++; end
        total++; if (pulses !== 0) $display("FAIL glitch_pulses: got %0d want 0", pulses); else passed++;
        total++; if (up_in !== 1'b0) $display("FAIL glitch_core_in: got %b want 0", up_in); else passed++;
        // Stable high: rise on the 18th cycle
        first = -1; pulses = 0;
        pad_in = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (up_rise) begin pulses++; if (first < 0) first = i; end
            if (up_fall) pulses++;
        end
        total++; if (first !== 18) $display("FAIL rise_cycle: got %0d want 18", first); else passed++;
        total++; if (pulses !== 1) $display("FAIL rise_count: got %0d want 1", pulses); else passed++;
        total++; if (up_in !== 1'b1) $display("FAIL rise_core_in: got %b want 1", up_in); else passed++;
    endtask

    task automatic test_reset_mid();
        // Drop the input and shift 3 bits, then reset in the middle of both
        pad_in = 1'b0;
        shift_bits(16'b111, 3);
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        #1;
        total++; if (up_cfg !== 5'b00000) $display("FAIL midrst_cfg: got %b want 00000", up_cfg); else passed++;
        total++; if (up_dm !== 3'b001 || up_oe_n !== 1'b1) $display("FAIL midrst_pad: got dm=%b oe_n=%b want 001/1", up_dm, up_oe_n); else passed++;
        total++; if (up_pout !== 1'b0 || up_in !== 1'b0) $display("FAIL midrst_out_in: got pad_out=%b core_in=%b want 0/0", up_pout, up_in); else passed++;
        total++; if (up_sdo !== 1'b0) $display("FAIL midrst_sdo: got %b want 0", up_sdo); else passed++;
        tick();
        rst_n = 1'b1;
        tick();
        // Partial shift was discarded: a bare load yields all zeros
        load_pulse();
        total++; if (up_cfg !== 5'b00000) $display("FAIL midrst_discard: got %b want 00000", up_cfg); else passed++;
        shift_bits(16'b10011, 5);
        total++; if (up_sdo !== 1'b1) $display("FAIL reload_sdo: got %b want 1", up_sdo); else passed++;
        load_pulse();
        total++; if (up_cfg !== 5'b10011) $display("FAIL reload_cfg: got %b want 10011", up_cfg); else passed++;
        total++; if (up_rise !== 1'b0 || up_fall !== 1'b0 || up_in !== 1'b0) $display("FAIL reload_in: got rise=%b fall=%b in=%b want 0/0/0", up_rise, up_fall, up_in); else passed++;
    endtask

    task automatic test_inp_dis_fall();
        int first;
        int pulses;
        pad_in = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        total++; if (up_in !== 1'b1) $display("FAIL pre_fall_core_in: got %b want 1", up_in); else passed++;
        shift_bits(16'b00111, 5);
        load_pulse();
        total++; if (up_idis !== 1'b1 || up_dm !== 3'b110) $display("FAIL inpdis_cfg: got idis=%b dm=%b want 1/110", up_idis, up_dm); else passed++;
        first = -1; pulses = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (up_fall) begin pulses++; if (first < 0) first = i; end
            if (up_rise) pulses++;
        end
        total++; if (first !== 16) $display("FAIL fall_cycle: got %0d want 16", first); else passed++;
        total++; if (pulses !== 1) $display("FAIL fall_count: got %0d want 1", pulses); else passed++;
        total++; if (up_in !== 1'b0) $display("FAIL fall_core_in: got %b want 0", up_in); else passed++;
    endtask

    task automatic test_chain();
        shift_bits(16'b00001_00010, 10);
        // Load together with an 11th shift: load sees the pre-shift contents
        ser_valid = 1'b1; ser_data = 1'b1; ser_load = 1'b1;
        tick();
        ser_valid = 1'b0; ser_data = 1'b0; ser_load = 1'b0;
        total++; if (dn_cfg !== 5'b00001 || dn_dm !== 3'b010) $display("FAIL chain_dn: got cfg=%b dm=%b want 00001/010", dn_cfg, dn_dm); else passed++;
        total++; if (up_cfg !== 5'b00010 || up_dm !== 3'b011) $display("FAIL chain_up: got cfg=%b dm=%b want 00010/011", up_cfg, up_dm); else passed++;
        total++; if (up_oe_n !== 1'b1) $display("FAIL chain_oe_n: got %b want 1", up_oe_n); else passed++;
        load_pulse();
        total++; if (up_cfg !== 5'b00101 || up_dm !== 3'b010) $display("FAIL same_cycle_up: got cfg=%b dm=%b want 00101/010", up_cfg, up_dm); else passed++;
        total++; if (dn_cfg !== 5'b00010 || dn_dm !== 3'b011) $display("FAIL same_cycle_dn: got cfg=%b dm=%b want 00010/011", dn_cfg, dn_dm); else passed++;
        total++; if (up_pout !== 1'b0) $display("FAIL pad_out_hold: got %b want 0", up_pout); else passed++;
    endtask

    initial begin
        test_reset();
        test_shift_load();
        test_debounce();
        test_reset_mid();
        test_inp_dis_fall();
        test_chain();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
